// File: rtl/rr_arb4_ctrl.sv
// rr_arb4_ctrl: four-requester round-robin arbiter that drives the select of a
// shared 4x1 data mux and captures the winning word into a valid/ready output
// register. A new word may be loaded in the same edge the old one is popped.
// Optional feature macro: RR_ARB4_LOCK_EN adds a 'lock' input that keeps the
// current winner at top priority (pointer parks on the winner, not past it).
module rr_arb4_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   req_data,
`ifdef RR_ARB4_LOCK_EN
    input  logic                  lock,
`endif
    output logic [3:0]            gnt,
    output logic                  out_valid,
    output logic [DATA_W-1:0]     out_data,
    output logic [1:0]            out_src,
    input  logic                  out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [1:0]          ptr_q, ptr_d;
    logic                valid_q, valid_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [1:0]          src_q, src_d;

    logic                can_load;
    logic                found;
    logic [1:0]          winner;
    logic                load;
    logic                park;

    // Rotating-priority search: scan ptr, ptr+1, ptr+2, ptr+3; nearest wins
    always_comb begin
        logic [1:0] idx;
        found  = 1'b0;
        winner = ptr_q;
        idx    = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

`ifdef RR_ARB4_LOCK_EN
    assign park = lock;
`else
    assign park = 1'b0;
`endif

    // Slot is free when empty or when the held word leaves this same edge;
    // grant is forced low while reset is asserted.
    assign can_load = (state_q == EMPTY) || out_ready;
    assign load     = can_load && found && rst_n;
    assign gnt      = load ? (4'b0001 << winner) : 4'b0000;

    // Next-state: load (possibly replacing a popped word), drain, or hold
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        valid_d = valid_q;
        data_d  = data_q;
        src_d   = src_q;
        if (load) begin
            state_d = FULL;
            valid_d = 1'b1;
            data_d  = req_data[winner*DATA_W +: DATA_W];
            src_d   = winner;
            ptr_d   = park ? winner : winner + 2'd1;
        end else if (state_q == FULL && out_ready) begin
            state_d = EMPTY;
            valid_d = 1'b0;
        end
    end

    // Controller state and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            ptr_q   <= 2'd0;
            valid_q <= 1'b0;
            data_q  <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            src_q   <= src_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign out_src   = src_q;

endmodule
